// File: rtl/miss_arbiter.sv
// Shared miss-service controller: round-robin grant across cache channels,
// one memory transaction at a time with fixed latency, one-cycle done pulse.
module miss_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 9,
    parameter int LINE_W  = 128,
    parameter int MEM_LAT = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        miss_valid,
    input  logic [NUM_CH-1:0]        miss_we,
    input  logic [NUM_CH*ADDR_W-1:0] miss_addr,
    input  logic [NUM_CH*LINE_W-1:0] miss_wline,
    output logic [NUM_CH-1:0]        done,
    output logic [LINE_W-1:0]        fill_line,
    output logic [ADDR_W-1:0]        fill_tag,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [LINE_W-1:0]        mem_wdata,
    input  logic [LINE_W-1:0]        mem_rdata,
    output logic                     busy
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] rr_ptr_reg;
    logic [IDX_W-1:0] winner_reg;
    logic [CNT_W-1:0] counter_reg;

    logic [ADDR_W-1:0] ch_addr  [NUM_CH];
    logic [LINE_W-1:0] ch_wline [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign ch_addr[gi]  = miss_addr[gi*ADDR_W +: ADDR_W];
            assign ch_wline[gi] = miss_wline[gi*LINE_W +: LINE_W];
        end
    endgenerate

    // Scan from the farthest offset down so the channel nearest after rr_ptr wins.
    logic [IDX_W-1:0] grant_next;
    logic             grant_any;
    logic [IDX_W-1:0] scan_idx;

    always_comb begin
        grant_next = rr_ptr_reg;
        grant_any  = 1'b0;
        scan_idx   = '0;
        for (int off = NUM_CH; off >= 1; off--) begin
            scan_idx = IDX_W'((int'(rr_ptr_reg) + off) % NUM_CH);
            if (miss_valid[scan_idx]) begin
                grant_next = scan_idx;
                grant_any  = 1'b1;
            end
        end
    end

    // mem_addr/mem_we/mem_wdata double as the latched copy of the granted request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            rr_ptr_reg  <= LAST_CH;
            winner_reg  <= '0;
            counter_reg <= '0;
            done        <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            fill_line   <= '0;
            fill_tag    <= '0;
        end else begin
            done   <= '0;
            mem_en <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        winner_reg <= grant_next;
                        rr_ptr_reg <= grant_next;
                        mem_we     <= miss_we[grant_next];
                        mem_addr   <= ch_addr[grant_next];
                        mem_wdata  <= ch_wline[grant_next];
                        mem_en     <= 1'b1;
                        state_reg  <= ISSUE;
                    end
                end
                ISSUE: begin
                    counter_reg <= CNT_INIT;
                    state_reg   <= WAIT;
                end
                WAIT: begin
                    if (counter_reg == '0) begin
                        if (!mem_we) begin
                            fill_line <= mem_rdata;
                        end
                        fill_tag          <= mem_addr;
                        done[winner_reg]  <= 1'b1;
                        state_reg         <= RESP;
                    end else begin
                        counter_reg <= counter_reg - CNT_W'(1);
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_reg != IDLE);

endmodule

// File: doc/miss_arbiter.md
Name: miss_arbiter

Overview:
- Parametrised miss-service controller between the pipeline caches (ICache, DCache, and any future channels) and the backing line memory.
- Accepts line-fill and line-writeback requests from NUM_CH cache channels and arbitrates them round-robin.
- Issues one request at a time to memory and waits a fixed MEM_LAT cycles.
- Returns the filled line and tag to the requesting channel as a one-cycle pulse. This replaces the per-cache ad-hoc fill paths (WiCache/WDCache) with one shared, channel-count-generic block.

Parameters:
- NUM_CH, 2, number of requesting cache channels (ch0 = ICache, ch1 = DCache by convention); must be >= 1.
- ADDR_W, 9, line-address/tag width.
- LINE_W, 128, cacheline width in bits.
- MEM_LAT, 3, memory cycles from mem_en to mem_rdata valid; must be >= 1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- miss_valid  in  NUM_CH  per-channel request; held high until that channel's done pulse
- miss_we  in  NUM_CH  per-channel op: 0 = line fill (read), 1 = writeback (write)
- miss_addr  in  NUM_CH*ADDR_W  per-channel line address; channel i at [i*ADDR_W +: ADDR_W]
- miss_wline  in  NUM_CH*LINE_W  per-channel writeback data; channel i at [i*LINE_W +: LINE_W]
- done  out  NUM_CH  one-hot, one-cycle completion pulse to the served channel
- fill_line  out  LINE_W  read line; valid while done is nonzero and the op was a read
- fill_tag  out  ADDR_W  address of the completed request; valid with done
- mem_en  out  1  one-cycle memory access strobe
- mem_we  out  1  write enable; qualified by mem_en
- mem_addr  out  ADDR_W  memory line address; held stable from mem_en until done
- mem_wdata  out  LINE_W  write line; held stable with mem_addr
- mem_rdata  in  LINE_W  read line; sampled MEM_LAT cycles after mem_en
- busy  out  1  high in every state except IDLE

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP.
- Reset (synchronous, dominant, takes effect at any state including mid-transaction):
  - state=IDLE, done=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, fill_line=0, fill_tag=0, busy=0, counter=0, rr_ptr=NUM_CH-1.
  - An in-flight request is dropped, with no done pulse; the requester re-requests after reset.
- IDLE:
  - If any miss_valid is set, select the winner: the first set bit scanning rr_ptr+1, rr_ptr+2, … mod NUM_CH.
  - Latch the winner index, miss_we, miss_addr and miss_wline; set rr_ptr = winner; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: mem_en=1 for this cycle only, counter=MEM_LAT-1, go to WAIT.
- WAIT:
  - If counter==0, capture mem_rdata into fill_line (reads only; writes leave fill_line unchanged) and go to RESP.
  - Otherwise counter-1.
- RESP:
  - done[winner]=1 for exactly one cycle, fill_tag = latched address; go to IDLE.
  - The requester must deassert miss_valid on the edge that samples done, so IDLE never re-grants a completed request.
- Latency:
  - Request sampled in IDLE at cycle T → mem_en at T+1 → mem_rdata sampled at T+1+MEM_LAT → done at T+2+MEM_LAT.
  - With MEM_LAT=3, done is at T+5.
- Back-to-back: the next grant can happen in the IDLE cycle right after RESP. Minimum spacing between done pulses is MEM_LAT+3 cycles.
- Fairness: with all channels requesting continuously, grants rotate 0,1,…,NUM_CH-1,0. No channel waits more than NUM_CH-1 transactions.
- Requests arriving or changing while busy are ignored until the next IDLE. The latched copy is used for the entire transaction.
- NUM_CH=1: rr_ptr is constant 0; behaviour is otherwise identical.
- done is never multi-hot; mem_en never asserts outside ISSUE.

Test Plan:
- Reset and idle: assert reset 2 cycles with miss_valid=0 → all outputs 0, busy=0. Hold 10 idle cycles → mem_en never pulses.
- Single read: miss_valid=01, miss_we=0, ch0 addr=9'h05, memory model returns 128'hDEAD…BEEF at MEM_LAT=3.
  - mem_en pulses at T+1 with mem_addr=5, mem_we=0.
  - done=01 at T+5, fill_line=DEAD…BEEF, fill_tag=5.
- Writeback: ch1 miss_we=1, addr=9'h1A0, wline=128'h1234… → mem_en at T+1 with mem_we=1, mem_addr=1A0, mem_wdata=1234… held through done. done=10 at T+5.
- Round-robin: both channels requesting continuously, each dropping valid after its done and re-raising it next cycle.
  - Grant order ch0, ch1, ch0, ch1.
  - done pulses spaced exactly 6 cycles apart (MEM_LAT=3).
- Reset mid-transaction: assert reset during WAIT → next cycle state=IDLE, busy=0, no done pulse. After release with the request still held, it is served from rr_ptr=NUM_CH-1 (ch0 first).
- Parameter sweep: NUM_CH=4, MEM_LAT=1, all four requesting → grants 0,1,2,3,0. Each done arrives 3 cycles after its grant cycle; done always one-hot.
